// File: rtl/sopc_v3_chip_select_out_if.sv
// Avalon-MM slave bus bundle for the chip-select output PIO.
// The master drives address/strobes/data; the slave returns registered readdata.
interface sopc_v3_chip_select_out_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/sopc_v3_chip_select_out.sv
// Single-bit output PIO with a hardware-timed pulse mode.
// The output sits at data_reg when idle.
// A PULSE_LEN write inverts the output for exactly N clocks, counted by a down-counter.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | out_port = data_reg, counter parked at 0
// PULSE | out_port = ~data_reg, counter holds the remaining cycles
module sopc_v3_chip_select_out #(
    parameter int unsigned PULSE_W     = 16,
    parameter bit          RESET_LEVEL = 1'b0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    sopc_v3_chip_select_out_if.slave    bus,
    output logic                        out_port
);

    typedef enum logic {
        IDLE  = 1'b0,
        PULSE = 1'b1
    } state_t;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_LEN    = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    state_t               state_q, state_d;
    logic [PULSE_W-1:0]   cnt_q, cnt_d;
    logic                 data_q, data_d;
    logic                 done_q, done_d;
    logic [31:0]          readdata_q, readdata_d;

    logic                 wr_en;
    logic                 wr_data;
    logic                 wr_len;
    logic                 wr_status_clr;
    logic [PULSE_W-1:0]   len_n;
    logic                 done_set;
    logic                 busy;

    // Only bit 0 (data), bit 1 (done clear) and the low PULSE_W bits (length) are meaningful.
    wire unused_writedata = &{1'b0, bus.writedata};

    // Decode the write strobe into per-register write enables.
    always_comb begin
        wr_en         = bus.chipselect & ~bus.write_n;
        wr_data       = wr_en && (bus.address == ADDR_DATA);
        wr_len        = wr_en && (bus.address == ADDR_LEN);
        wr_status_clr = wr_en && (bus.address == ADDR_STATUS) && bus.writedata[1];
        len_n         = bus.writedata[PULSE_W-1:0];
        busy          = (state_q == PULSE);
    end

    // Next-state, pulse counter and done-flag logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_set = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (wr_len && (len_n != '0)) begin
                    state_d = PULSE;
                    cnt_d   = len_n;
                end
            end
            PULSE: begin
                if (wr_len) begin
                    // Non-zero length restarts the full window; zero aborts without flagging done.
                    if (len_n != '0) begin
                        cnt_d = len_n;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (cnt_q <= PULSE_W'(1)) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    done_set = 1'b1;
                end else begin
                    cnt_d = cnt_q - PULSE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        data_d = wr_data ? bus.writedata[0] : data_q;

        // Completion outranks a simultaneous software clear so a finished pulse is never lost.
        if (done_set) begin
            done_d = 1'b1;
        end else if (wr_status_clr) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    // Read mux, captured every cycle; reads have no side effects.
    always_comb begin
        readdata_d = '0;
        unique case (bus.address)
            ADDR_DATA:   readdata_d = {31'b0, data_q};
            ADDR_LEN:    readdata_d = 32'(cnt_q);
            ADDR_STATUS: readdata_d = {30'b0, done_q, busy};
            default:     readdata_d = '0;
        endcase
    end

    // Register all state; async reset forces the output straight to its idle level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_q     <= RESET_LEVEL;
            done_q     <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
        end
    end

    // Output is derived from registered state only, using the live data bit during a pulse.
    always_comb begin
        out_port     = busy ? ~data_q : data_q;
        bus.readdata = readdata_q;
    end

endmodule

// File: tb/tb_sopc_v3_chip_select_out.sv
// Directed bench for the chip-select output PIO.
// Inputs change and outputs are sampled on the falling edge.
module tb_sopc_v3_chip_select_out;

    logic clk;
    logic reset_n;
    logic out_port;

    int total;
    int bad;
    int hi_cnt;
    logic [31:0] rd_val;

    sopc_v3_chip_select_out_if bus ();

    sopc_v3_chip_select_out #(
        .PULSE_W     (16),
        .RESET_LEVEL (1'b0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .out_port (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: record whether the output is high at this falling edge, then advance.
    task automatic tick();
        if (out_port === 1'b1) hi_cnt++;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'hFFFF_FFFF;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        tick();
        d = bus.readdata;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        hi_cnt         = 0;
        reset_n        = 1'b0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'h0;

        // Reset state
        #12;
        chk("rst_out", {31'b0, out_port}, 32'h0);
        chk("rst_rdata", bus.readdata, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rd(2'd2, rd_val);
        chk("rst_status", rd_val, 32'h0);

        // Static level
        wr(2'd0, 32'h1);
        chk("data1_out", {31'b0, out_port}, 32'h1);
        rd(2'd0, rd_val);
        chk("data1_rd", rd_val, 32'h1);
        wr(2'd0, 32'hFFFF_FFFE);
        chk("data0_out", {31'b0, out_port}, 32'h0);

        // 5-cycle pulse
        hi_cnt = 0;
        wr(2'd1, 32'h5);
        bus.address = 2'd2;
        tick();
        chk("p5_busy", bus.readdata, 32'h1);
        ticks(12);
        chk("p5_width", hi_cnt, 32'd5);
        chk("p5_status_done", bus.readdata, 32'h2);
        rd(2'd1, rd_val);
        chk("p5_cnt_end", rd_val, 32'h0);
        wr(2'd2, 32'h2);
        rd(2'd2, rd_val);
        chk("p5_status_clr", rd_val, 32'h0);

        // Retrigger: 10 then 4 three cycles later
        hi_cnt = 0;
        wr(2'd1, 32'd10);
        ticks(2);
        wr(2'd1, 32'd4);
        bus.address = 2'd1;
        tick();
        chk("retrig_cnt", bus.readdata, 32'd4);
        ticks(20);
        chk("retrig_width", hi_cnt, 32'd7);
        rd(2'd2, rd_val);
        chk("retrig_status", rd_val, 32'h2);
        wr(2'd2, 32'h2);

        // Abort after 2 cycles
        hi_cnt = 0;
        wr(2'd1, 32'd8);
        tick();
        wr(2'd1, 32'd0);
        chk("abort_out", {31'b0, out_port}, 32'h0);
        ticks(10);
        chk("abort_width", hi_cnt, 32'd2);
        rd(2'd2, rd_val);
        chk("abort_status", rd_val, 32'h0);
        rd(2'd1, rd_val);
        chk("abort_cnt", rd_val, 32'h0);
        wr(2'd1, 32'h0);
        chk("len0_idle_out", {31'b0, out_port}, 32'h0);
        rd(2'd2, rd_val);
        chk("len0_idle_status", rd_val, 32'h0);

        // Clear coinciding with completion: set wins
        wr(2'd1, 32'd3);
        ticks(2);
        wr(2'd2, 32'h2);
        chk("clr_race_out", {31'b0, out_port}, 32'h0);
        rd(2'd2, rd_val);
        chk("clr_race_status", rd_val, 32'h2);
        wr(2'd2, 32'h2);

        // DATA write during a pulse flips the output from the next cycle
        wr(2'd1, 32'd4);
        chk("live_pre", {31'b0, out_port}, 32'h1);
        wr(2'd0, 32'h1);
        chk("live_inv", {31'b0, out_port}, 32'h0);
        ticks(6);
        chk("live_idle", {31'b0, out_port}, 32'h1);
        wr(2'd0, 32'h0);
        wr(2'd2, 32'h2);

        // Reset mid-pulse
        wr(2'd1, 32'd6);
        tick();
        chk("midrst_pre", {31'b0, out_port}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("midrst_out", {31'b0, out_port}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd(2'd2, rd_val);
        chk("midrst_status", rd_val, 32'h0);
        rd(2'd1, rd_val);
        chk("midrst_cnt", rd_val, 32'h0);

        // chipselect low blocks writes
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b0;
        bus.address    = 2'd0;
        bus.writedata  = 32'h1;
        tick();
        bus.address    = 2'd1;
        bus.writedata  = 32'd5;
        tick();
        bus.write_n    = 1'b1;
        chk("nocs_out", {31'b0, out_port}, 32'h0);
        rd(2'd0, rd_val);
        chk("nocs_data", rd_val, 32'h0);
        rd(2'd2, rd_val);
        chk("nocs_status", rd_val, 32'h0);

        // Reserved address reads zero and ignores writes
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, rd_val);
        chk("rsvd_rd", rd_val, 32'h0);
        chk("rsvd_out", {31'b0, out_port}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Backstop so the run always ends even if a step stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
